// File: rtl/risc_pkg.sv
// Shared encodings and the combinational instruction cracker for the decode stage.
package risc_pkg;

  localparam int unsigned InstrW = 16;
  localparam int unsigned PcW    = 16;
  localparam int unsigned RegW   = 3;
  localparam int unsigned OpW    = 4;

  localparam logic [OpW-1:0] OpAdd  = 4'h0;
  localparam logic [OpW-1:0] OpSub  = 4'h1;
  localparam logic [OpW-1:0] OpAnd  = 4'h2;
  localparam logic [OpW-1:0] OpOr   = 4'h3;
  localparam logic [OpW-1:0] OpXor  = 4'h4;
  localparam logic [OpW-1:0] OpSlt  = 4'h5;
  localparam logic [OpW-1:0] OpAddi = 4'h8;
  localparam logic [OpW-1:0] OpLw   = 4'hA;
  localparam logic [OpW-1:0] OpSw   = 4'hC;
  localparam logic [OpW-1:0] OpBeq  = 4'hD;
  localparam logic [OpW-1:0] OpJmp  = 4'hE;
  localparam logic [OpW-1:0] OpNop  = 4'hF;

  localparam logic [InstrW-1:0] NopWord = 16'hFFFF;

  typedef struct packed {
    logic [OpW-1:0]  opcode;
    logic [RegW-1:0] rd;
    logic [RegW-1:0] rs;
    logic [RegW-1:0] rt;
    logic [15:0]     imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            is_beq;
    logic            is_jmp;
    logic            illegal;
    logic [7:0]      offset;
    logic [11:0]     addr;
  } dec_t;

  // Register read enables, ordered {rs, rt, rd}.
  function automatic logic [2:0] src_mask(input logic [InstrW-1:0] instr);
    logic [2:0] m;
    case (instr[15:12])
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt: m = 3'b110;
      OpAddi, OpLw:                            m = 3'b100;
      OpSw:                                    m = 3'b101;
      default:                                 m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic dec_t crack(input logic [InstrW-1:0] instr);
    dec_t d;
    d        = '0;
    d.opcode = instr[15:12];
    d.rd     = instr[11:9];
    d.rs     = instr[8:6];
    d.rt     = instr[5:3];
    d.imm    = {{10{instr[5]}}, instr[5:0]};
    d.offset = instr[7:0];
    d.addr   = instr[11:0];
    case (instr[15:12])
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpAddi: d.reg_write = (d.rd != '0);
      OpLw: begin
        d.reg_write = (d.rd != '0);
        d.mem_read  = 1'b1;
      end
      OpSw:  d.mem_write = 1'b1;
      OpBeq: d.is_beq    = 1'b1;
      OpJmp: d.is_jmp    = 1'b1;
      OpNop: ;
      default: begin
        d.illegal = 1'b1;
        d.opcode  = NopWord[15:12];
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_skid_fifo.sv
// Small circular buffer of {pc, instr} words feeding the decode stage; flush empties it at once.
module decode_skid_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [Width-1:0]           o_data,
  output logic [$clog2(Depth+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]  r_count, w_count_nxt;
  logic             w_do_push, w_do_pop;

  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != DepthC) || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CntW'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_do_push) r_wr_ptr <= bump(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= bump(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: skid-buffers fetched words, cracks them, stalls on RAW hazards via a scoreboard,
// issues to execute with valid/ready and redirects fetch on taken branches and jumps.
module instruction_decode
  import risc_pkg::*;
#(
  parameter int unsigned SKID_DEPTH   = 2,
  parameter int unsigned SQUASH_SLOTS = 1,
  parameter int unsigned NUM_REGS     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [InstrW-1:0] if_instruction,
  input  logic [PcW-1:0]    if_pc,
  input  logic              if_valid,
  output logic              id_hold,
  input  logic              ex_ready,
  input  logic              ex_zero,
  input  logic              wb_valid,
  input  logic [RegW-1:0]   wb_rd,
  output logic              id_valid,
  output logic [PcW-1:0]    id_pc,
  output logic [OpW-1:0]    id_opcode,
  output logic [RegW-1:0]   id_rd,
  output logic [RegW-1:0]   id_rs,
  output logic [RegW-1:0]   id_rt,
  output logic [15:0]       id_imm,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              branch,
  output logic              jump,
  output logic [7:0]        branch_offset,
  output logic [11:0]       jump_address,
  output logic              illegal_instr
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SqW  = $clog2(SQUASH_SLOTS + 1);
  localparam logic [CntW-1:0] HoldLvl = CntW'(SKID_DEPTH - 1);
  localparam logic [SqW-1:0]  SqFull  = SqW'(SQUASH_SLOTS);
  localparam logic [SqW-1:0]  SqLess  = SqW'(SQUASH_SLOTS - 1);

  logic                  r_valid, r_fresh;
  logic [PcW-1:0]        r_pc;
  dec_t                  r_dec;
  logic [NUM_REGS-1:0]   r_pending, w_pending_nxt, w_busy;
  logic [SqW-1:0]        r_squash_cnt;

  logic [PcW+InstrW-1:0] w_fifo_data;
  logic [CntW-1:0]       w_fifo_count;
  logic                  w_fifo_empty;
  logic [PcW-1:0]        w_head_pc;
  logic [InstrW-1:0]     w_head_instr;
  dec_t                  w_head_dec;
  logic [2:0]            w_head_src;
  logic                  w_redirect, w_squash, w_in_accept, w_head_valid;
  logic                  w_hazard, w_load, w_push, w_pop;

  // Redirect is judged on the first valid cycle only; ex_zero is sampled in that same cycle.
  assign w_redirect  = r_valid && r_fresh && (r_dec.is_jmp || (r_dec.is_beq && ex_zero));
  assign w_squash    = w_redirect || (r_squash_cnt != '0);
  assign w_in_accept = if_valid && !w_squash;

  // An empty buffer lets the arriving word go straight to the output register.
  assign w_head_valid = !w_fifo_empty || w_in_accept;
  assign {w_head_pc, w_head_instr} = w_fifo_empty ? {if_pc, if_instruction} : w_fifo_data;
  assign w_head_dec   = crack(w_head_instr);
  assign w_head_src   = src_mask(w_head_instr);

  // Busy = pending and not retiring this cycle, or written by the op leaving the output register.
  always_comb begin
    w_busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_busy[i] = (r_pending[i] && !(wb_valid && (wb_rd == RegW'(i))))
                || (r_valid && r_dec.reg_write && (r_dec.rd == RegW'(i)));
    end
  end

  assign w_hazard = (w_head_src[2] && w_busy[w_head_dec.rs])
                 || (w_head_src[1] && w_busy[w_head_dec.rt])
                 || (w_head_src[0] && w_busy[w_head_dec.rd]);

  assign w_load = w_head_valid && (!r_valid || ex_ready) && !w_hazard && !w_redirect;
  assign w_pop  = w_load && !w_fifo_empty;
  assign w_push = w_in_accept && !(w_load && w_fifo_empty);

  decode_skid_fifo #(
    .Depth (SKID_DEPTH),
    .Width (PcW + InstrW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({if_pc, if_instruction}),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // Set on issue wins over a same-cycle writeback clear.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_rd] = 1'b0;
    if (r_valid && ex_ready && r_dec.reg_write) w_pending_nxt[r_dec.rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_fresh      <= 1'b0;
      r_pc         <= '0;
      r_dec        <= '0;
      r_pending    <= '0;
      r_squash_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_fresh   <= w_load;
      if (w_load) begin
        r_valid <= 1'b1;
        r_pc    <= w_head_pc;
        r_dec   <= w_head_dec;
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end
      // The word arriving alongside the redirect already counts as the first discarded slot.
      if (w_redirect) begin
        r_squash_cnt <= if_valid ? SqLess : SqFull;
      end else if ((r_squash_cnt != '0) && if_valid) begin
        r_squash_cnt <= r_squash_cnt - SqW'(1);
      end
    end
  end

  assign id_hold       = !reset && (w_fifo_count >= HoldLvl);
  assign id_valid      = r_valid;
  assign id_pc         = r_pc;
  assign id_opcode     = r_dec.opcode;
  assign id_rd         = r_dec.rd;
  assign id_rs         = r_dec.rs;
  assign id_rt         = r_dec.rt;
  assign id_imm        = r_dec.imm;
  assign id_reg_write  = r_dec.reg_write;
  assign id_mem_read   = r_dec.mem_read;
  assign id_mem_write  = r_dec.mem_write;
  assign branch        = r_valid && r_fresh && r_dec.is_beq;
  assign jump          = r_valid && r_fresh && r_dec.is_jmp;
  assign branch_offset = r_dec.offset;
  assign jump_address  = r_dec.addr;
  assign illegal_instr = r_valid && r_fresh && r_dec.illegal;

endmodule
